// File: rtl/sp_ram_pkg.sv
// Shared definitions for the banked single-port RAM.
//   RDW_* constants : read-during-write response modes
//   state_e         : clear-sequencer states
//   lane_parity     : even-parity bit of one write lane (zero-extended input)
package sp_ram_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;
  localparam int unsigned RDW_NO_CHANGE   = 2;

  // Widest lane the parity helper accepts; callers zero-extend to this width.
  localparam int unsigned LANE_MAX_W = 64;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Even parity: stored bit makes the total count of ones in lane+bit even.
  function automatic logic lane_parity(input logic [LANE_MAX_W-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/sp_ram_banked_if.sv
// Request/response bundle between a master and sp_ram_banked.
//   master drives : en, we, be, addr, data, clr
//   slave drives  : q, q_valid, busy, perr
interface sp_ram_banked_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned BYTE_W = 8
);
  localparam int unsigned NB = DATA_W / BYTE_W;

  logic              en;
  logic              we;
  logic [NB-1:0]     be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              clr;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              busy;
  logic              perr;

  modport master (output en, we, be, addr, data, clr,
                  input  q, q_valid, busy, perr);
  modport slave  (input  en, we, be, addr, data, clr,
                  output q, q_valid, busy, perr);
endinterface

// File: rtl/sp_ram_clear_seq.sv
// Clear sequencer: owns the CLEAR/READY FSM and the sweep address.
//   clk, rst   : clock, async active-high reset (restarts the sweep)
//   clr        : start a new sweep when READY (ignored while clearing)
//   busy       : sweep in progress; also selects the sweep onto the write port
//   sweep_addr : word being zeroed this cycle
module sp_ram_clear_seq
  import sp_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [0:0]        S_CLEAR   = CLEAR;
  localparam logic [0:0]        S_READY   = READY;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [ADDR_W-1:0] addr_next;

  // Next-state and sweep counter.
  always_comb begin
    state_next = state;
    addr_next  = sweep_addr;
    case (state)
      S_CLEAR: begin
        if (sweep_addr == LAST_ADDR) begin
          state_next = S_READY;
          addr_next  = '0;
        end else begin
          addr_next = sweep_addr + ADDR_W'(1);
        end
      end
      S_READY: begin
        if (clr) begin
          state_next = S_CLEAR;
          addr_next  = '0;
        end
      end
      default: begin
        state_next = S_CLEAR;
        addr_next  = '0;
      end
    endcase
  end

  // busy falls on the same edge that writes the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_CLEAR;
      sweep_addr <= '0;
      busy       <= 1'b1;
    end else begin
      state      <= state_next;
      sweep_addr <= addr_next;
      busy       <= (state_next == S_CLEAR);
    end
  end

endmodule

// File: rtl/sp_ram_banked.sv
// Single-port synchronous RAM with byte-lane writes, selectable
// read-during-write response, optional output register and a clear sweep.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of sp_ram_banked_if (en/we/be/addr/data/clr in,
//              q/q_valid/busy/perr out)
// Optional feature: define SP_RAM_PARITY_EN to store one even-parity bit per
// lane and flag mismatches on perr; otherwise perr is tied low.
module sp_ram_banked
  import sp_ram_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned BYTE_W   = 8,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned OUT_REG  = 0
) (
  input logic           clk,
  input logic           rst,
  sp_ram_banked_if.slave bus
);

  localparam int unsigned       NB      = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic [ADDR_W-1:0] sweep_addr;

  logic              acc_c;
  logic              wr_c;
  logic              in_range_c;
  logic [DATA_W-1:0] old_word_c;
  logic [DATA_W-1:0] merged_c;
  logic [DATA_W-1:0] resp_q_c;
  logic              resp_v_c;
  logic              perr_c;

  logic [DATA_W-1:0] q1;
  logic              v1;
  logic              p1;

  sp_ram_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.clr),
    .busy       (busy),
    .sweep_addr (sweep_addr)
  );

  assign bus.busy = busy;

  // clr wins over a same-cycle access; nothing is accepted while sweeping.
  assign acc_c      = bus.en & ~busy & ~bus.clr;
  assign in_range_c = ({1'b0, bus.addr} < DEPTH_L);
  assign wr_c       = acc_c & bus.we & in_range_c;
  assign old_word_c = in_range_c ? mem[bus.addr] : '0;

  // Lane merge of write data over the stored word.
  always_comb begin
    merged_c = old_word_c;
    for (int i = 0; i < NB; i++) begin
      if (bus.be[i]) merged_c[i*BYTE_W +: BYTE_W] = bus.data[i*BYTE_W +: BYTE_W];
    end
  end

  // Response selection; out-of-range accesses always answer zero.
  always_comb begin
    resp_v_c = acc_c & (~bus.we | (RDW_MODE != RDW_NO_CHANGE));
    if (!in_range_c)
      resp_q_c = '0;
    else if (bus.we && (RDW_MODE == RDW_WRITE_FIRST))
      resp_q_c = merged_c;
    else
      resp_q_c = old_word_c;
  end

  // Single write port, muxed between the sweep and the master.
  always_ff @(posedge clk) begin
    if (busy)      mem[sweep_addr] <= '0;
    else if (wr_c) mem[bus.addr]   <= merged_c;
  end

`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] old_par_c;
  logic [NB-1:0] new_par_c;
  logic [NB-1:0] resp_par_c;

  // Parity follows the same merge/select path as the data.
  always_comb begin
    old_par_c = in_range_c ? par_mem[bus.addr] : '0;
    new_par_c = old_par_c;
    for (int i = 0; i < NB; i++) begin
      if (bus.be[i]) new_par_c[i] = lane_parity(LANE_MAX_W'(bus.data[i*BYTE_W +: BYTE_W]));
    end
    resp_par_c = (in_range_c && bus.we && (RDW_MODE == RDW_WRITE_FIRST)) ? new_par_c : old_par_c;
    perr_c = 1'b0;
    for (int i = 0; i < NB; i++) begin
      perr_c = perr_c | (lane_parity(LANE_MAX_W'(resp_q_c[i*BYTE_W +: BYTE_W])) != resp_par_c[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (busy)      par_mem[sweep_addr] <= '0;
    else if (wr_c) par_mem[bus.addr]   <= new_par_c;
  end
`else
  assign perr_c = 1'b0;
`endif

  // First response stage; q holds when no response is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1 <= '0;
      v1 <= 1'b0;
      p1 <= 1'b0;
    end else begin
      v1 <= resp_v_c;
      p1 <= resp_v_c & perr_c;
      if (resp_v_c) q1 <= resp_q_c;
    end
  end

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic [DATA_W-1:0] q2;
      logic              v2;
      logic              p2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q2 <= '0;
          v2 <= 1'b0;
          p2 <= 1'b0;
        end else begin
          v2 <= v1;
          p2 <= p1;
          if (v1) q2 <= q1;
        end
      end

      assign bus.q       = q2;
      assign bus.q_valid = v2;
      assign bus.perr    = p2;
    end else begin : g_no_out_reg
      assign bus.q       = q1;
      assign bus.q_valid = v1;
      assign bus.perr    = p1;
    end
  endgenerate

endmodule

// File: tb/tb_sp_ram_banked.sv
// Bench for sp_ram_banked: three 8-bit instances sharing one request stream
// (READ_FIRST/no out reg, WRITE_FIRST/out reg, NO_CHANGE/no out reg) plus one
// 32-bit READ_FIRST instance for lane-merge tests. Responses are scored
// against a reference array through per-instance expectation queues.
module tb_sp_ram_banked;

  typedef struct {
    logic [31:0] d;
    int          req;
    logic        perr;
    string       tag;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  sb_t sb0[$];
  sb_t sb1[$];
  sb_t sb2[$];
  sb_t sb3[$];

  logic [7:0]  ref8  [64];
  logic [31:0] ref32 [64];
  logic [7:0]  last2;
  logic        exp_perr;

  sp_ram_banked_if #(.DATA_W(8),  .ADDR_W(6), .BYTE_W(8)) if0 ();
  sp_ram_banked_if #(.DATA_W(8),  .ADDR_W(6), .BYTE_W(8)) if1 ();
  sp_ram_banked_if #(.DATA_W(8),  .ADDR_W(6), .BYTE_W(8)) if2 ();
  sp_ram_banked_if #(.DATA_W(32), .ADDR_W(6), .BYTE_W(8)) if3 ();

  assign if1.en = if0.en;  assign if1.we = if0.we;  assign if1.be = if0.be;
  assign if1.addr = if0.addr;  assign if1.data = if0.data;  assign if1.clr = if0.clr;
  assign if2.en = if0.en;  assign if2.we = if0.we;  assign if2.be = if0.be;
  assign if2.addr = if0.addr;  assign if2.data = if0.data;  assign if2.clr = if0.clr;

  sp_ram_banked #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .BYTE_W(8), .RDW_MODE(0), .OUT_REG(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  sp_ram_banked #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .BYTE_W(8), .RDW_MODE(1), .OUT_REG(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  sp_ram_banked #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .BYTE_W(8), .RDW_MODE(2), .OUT_REG(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));
  sp_ram_banked #(.DATA_W(32), .ADDR_W(6), .DEPTH(64), .BYTE_W(8), .RDW_MODE(0), .OUT_REG(0))
    dut3 (.clk(clk), .rst(rst), .bus(if3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string who, input sb_t e, input logic [31:0] obs,
                     input logic pobs, input int lat);
    chk({who, "_", e.tag, "_q"}, obs, e.d);
    chk({who, "_", e.tag, "_lat"}, 32'(cyc - e.req + 1), 32'(lat));
    chk({who, "_", e.tag, "_perr"}, 32'(pobs), 32'(e.perr));
  endtask

  // Response monitors: every q_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (if0.q_valid === 1'b1) begin
      checks++;
      assert (sb0.size() > 0) else begin errors++; $error("FAIL d0_spurious observed=valid expected=none"); end
      if (sb0.size() > 0) cmp("d0", sb0.pop_front(), 32'(if0.q), if0.perr, 1);
    end
    if (if1.q_valid === 1'b1) begin
      checks++;
      assert (sb1.size() > 0) else begin errors++; $error("FAIL d1_spurious observed=valid expected=none"); end
      if (sb1.size() > 0) cmp("d1", sb1.pop_front(), 32'(if1.q), if1.perr, 2);
    end
    if (if2.q_valid === 1'b1) begin
      checks++;
      assert (sb2.size() > 0) else begin errors++; $error("FAIL d2_spurious observed=valid expected=none"); end
      if (sb2.size() > 0) cmp("d2", sb2.pop_front(), 32'(if2.q), if2.perr, 1);
    end
    if (if3.q_valid === 1'b1) begin
      checks++;
      assert (sb3.size() > 0) else begin errors++; $error("FAIL d3_spurious observed=valid expected=none"); end
      if (sb3.size() > 0) cmp("d3", sb3.pop_front(), if3.q, if3.perr, 1);
    end
  end

  task automatic idle8();
    if0.en = 1'b0; if0.we = 1'b0; if0.be = '0; if0.addr = '0; if0.data = '0; if0.clr = 1'b0;
  endtask

  // One 8-bit access to the shared stream; expectations come from ref8.
  task automatic acc8(input logic w, input logic [5:0] a, input logic [7:0] d, input logic b);
    logic [7:0] old;
    logic [7:0] nw;
    sb_t e;
    old = ref8[a];
    nw  = b ? d : old;
    if0.en = 1'b1; if0.we = w; if0.be = b; if0.addr = a; if0.data = d;
    e.req = cyc + 1; e.perr = w ? 1'b0 : exp_perr; e.tag = w ? "wr" : "rd";
    e.d = 32'(old);
    sb0.push_back(e);
    e.d = 32'(w ? nw : old);
    sb1.push_back(e);
    if (!w) begin
      e.d = 32'(old);
      sb2.push_back(e);
      last2 = old;
    end else begin
      ref8[a] = nw;
    end
    @(negedge clk);
    idle8();
    if (w) begin
      chk("nc_wr_qv", 32'(if2.q_valid), 32'd0);
      chk("nc_wr_hold", 32'(if2.q), 32'(last2));
    end
  endtask

  task automatic acc32(input logic w, input logic [5:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] nw;
    sb_t e;
    nw = ref32[a];
    for (int i = 0; i < 4; i++) if (b[i]) nw[i*8 +: 8] = d[i*8 +: 8];
    if3.en = 1'b1; if3.we = w; if3.be = b; if3.addr = a; if3.data = d;
    e.req = cyc + 1; e.perr = 1'b0; e.tag = w ? "wr32" : "rd32"; e.d = ref32[a];
    sb3.push_back(e);
    if (w) ref32[a] = nw;
    @(negedge clk);
    if3.en = 1'b0; if3.we = 1'b0; if3.be = '0;
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_sb0_left"}, 32'(sb0.size()), 32'd0);
    chk({tag, "_sb1_left"}, 32'(sb1.size()), 32'd0);
    chk({tag, "_sb2_left"}, 32'(sb2.size()), 32'd0);
    chk({tag, "_sb3_left"}, 32'(sb3.size()), 32'd0);
  endtask

  // Counts busy cycles with a bound so a stuck busy cannot hang the run.
  task automatic check_busy(input string tag);
    int n;
    n = 0;
    while (if0.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n), 32'd64);
    chk({tag, "_d1"}, 32'(if1.busy), 32'd0);
  endtask

  task automatic pulse_clr(input logic with_en);
    if0.clr = 1'b1; if0.en = with_en; if0.we = 1'b1; if0.be = 1'b1;
    if0.addr = 6'd3; if0.data = 8'h55;
    @(negedge clk);
    idle8();
    for (int i = 0; i < 64; i++) ref8[i] = 8'h00;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_q0"},  32'(if0.q),       32'd0);
    chk({tag, "_q1"},  32'(if1.q),       32'd0);
    chk({tag, "_q2"},  32'(if2.q),       32'd0);
    chk({tag, "_qv0"}, 32'(if0.q_valid), 32'd0);
    chk({tag, "_qv1"}, 32'(if1.q_valid), 32'd0);
    chk({tag, "_pe0"}, 32'(if0.perr),    32'd0);
    chk({tag, "_busy"}, 32'(if0.busy),   32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle8();
    if3.en = 1'b0; if3.we = 1'b0; if3.be = '0; if3.addr = '0; if3.data = '0; if3.clr = 1'b0;
    for (int i = 0; i < 64; i++) begin ref8[i] = 8'h00; ref32[i] = 32'h0; end
    last2 = 8'h00;
    exp_perr = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    check_busy("init_busy");

    // Freshly cleared array reads zero, including the last word.
    acc8(1'b0, 6'd10, 8'h00, 1'b0);
    acc8(1'b0, 6'd63, 8'h00, 1'b0);
    drain("t1");

    // Basic writes then back-to-back reads.
    acc8(1'b1, 6'd0, 8'h01, 1'b1);
    acc8(1'b1, 6'd1, 8'h02, 1'b1);
    acc8(1'b1, 6'd2, 8'h03, 1'b1);
    acc8(1'b0, 6'd0, 8'h00, 1'b0);
    acc8(1'b0, 6'd1, 8'h00, 1'b0);
    acc8(1'b0, 6'd2, 8'h00, 1'b0);
    drain("t2");

    // Read-during-write modes, read-after-write, and a be=0 no-op write.
    acc8(1'b1, 6'd1, 8'h04, 1'b1);
    acc8(1'b0, 6'd1, 8'h00, 1'b0);
    acc8(1'b1, 6'd1, 8'hFF, 1'b0);
    acc8(1'b0, 6'd1, 8'h00, 1'b0);
    drain("t4");

    // 32-bit lane merge.
    acc32(1'b1, 6'd5, 32'hAABBCCDD, 4'hF);
    acc32(1'b1, 6'd5, 32'h11223344, 4'b0101);
    acc32(1'b0, 6'd5, 32'h0, 4'h0);
    drain("t3");

`ifdef SP_RAM_PARITY_EN
    acc8(1'b1, 6'd4, 8'h0F, 1'b1);
    acc8(1'b1, 6'd5, 8'h0F, 1'b1);
    drain("t6w");
    dut0.mem[4] = 8'h0E;
    dut1.mem[4] = 8'h0E;
    dut2.mem[4] = 8'h0E;
    ref8[4] = 8'h0E;
    exp_perr = 1'b1;
    acc8(1'b0, 6'd4, 8'h00, 1'b0);
    exp_perr = 1'b0;
    acc8(1'b0, 6'd5, 8'h00, 1'b0);
    drain("t6");
`else
    acc8(1'b0, 6'd2, 8'h00, 1'b0);
    drain("t6");
`endif

    // clr with a same-cycle write: write dropped, array cleared.
    pulse_clr(1'b1);
    check_busy("clr_busy");
    acc8(1'b0, 6'd3, 8'h00, 1'b0);
    acc8(1'b0, 6'd1, 8'h00, 1'b0);
    drain("t5");

    // Leave nonzero data on q, then reset in the middle of a sweep.
    acc8(1'b1, 6'd7, 8'h5A, 1'b1);
    acc8(1'b0, 6'd7, 8'h00, 1'b0);
    drain("t5b");
    pulse_clr(1'b0);
    repeat (29) @(negedge clk);
    chk("mid_sweep_busy", 32'(if0.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    last2 = 8'h00;
    for (int i = 0; i < 64; i++) ref32[i] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_busy("restart_busy");
    acc8(1'b0, 6'd7, 8'h00, 1'b0);
    acc8(1'b0, 6'd0, 8'h00, 1'b0);
    drain("t5c");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sp_ram_banked.md
# sp_ram_banked

Parametrised single-port synchronous RAM; the next generation of the team's single-port RAM. It adds byte-lane write enables, a selectable read-during-write mode, an optional output pipeline register, a read-valid strobe, and a hardware clear sequencer that zeroes the array after reset or on request. It sits wherever local scratch storage is needed, between a requesting master and nothing else, with one access per cycle.

## Interface
- DATA_W, 8, word width in bits; must be a multiple of BYTE_W.
- ADDR_W, 6, address width.
- DEPTH, 64, number of words; must satisfy DEPTH ≤ 2**ADDR_W.
- BYTE_W, 8, bits per write lane; NB = DATA_W/BYTE_W lanes.
- RDW_MODE, 0, read-during-write behaviour: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- OUT_REG, 0, adds one output pipeline stage when set to 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  access request, sampled every cycle.
- we  in  1  1 = write, 0 = read; qualified by en.
- be  in  NB  byte-lane write enables; lane i covers data[i*BYTE_W +: BYTE_W].
- addr  in  ADDR_W  word address.
- data  in  DATA_W  write data.
- clr  in  1  single-cycle pulse that starts a clear sweep.
- q  out  DATA_W  read data.
- q_valid  out  1  q carries the result of an accepted access.
- busy  out  1  clear sweep in progress; requests are not accepted.
- perr  out  1  parity error on the current q; see Configuration.

## Operation
- FSM states:
  - CLEAR: writes 0 to word sweep_addr with all lanes enabled, then increments sweep_addr. When sweep_addr = DEPTH-1, the FSM moves to READY.
  - READY: serves requests.
- Reset forces CLEAR with sweep_addr = 0. Array contents are cleared only by the sweep.
- In READY, clr = 1 moves the FSM to CLEAR with sweep_addr = 0. If en is also high in that cycle, the access is dropped (clr has priority).
- clr during CLEAR is ignored; the current sweep continues.
- en during CLEAR is ignored, with no q_valid. The master must hold off while busy = 1.
- Write (en & we & READY): only lanes with be[i] = 1 are updated. be = 0 is a legal no-op write.
- Read (en & ~we & READY): returns mem[addr].
- Response to a write:
  - READ_FIRST: q = old word, q_valid = 1.
  - WRITE_FIRST: q = merged new word, q_valid = 1.
  - NO_CHANGE: q holds its value, q_valid = 0.
- Out-of-range address (addr ≥ DEPTH): writes are discarded; reads return 0 with q_valid = 1.
- q holds its last value when no response is issued.

## Timing
- Reset values: q = 0, q_valid = 0, perr = 0, busy = 1. FSM is in CLEAR, sweep_addr = 0.
- Clear sweep takes DEPTH cycles after rst deassertion, or after the clr cycle. busy deasserts on the edge that writes DEPTH-1. The first request can be accepted on the following cycle.
- Read latency from the request edge: 1 cycle when OUT_REG = 0, 2 cycles when OUT_REG = 1. q_valid is aligned with q.
- Fully pipelined: one request per cycle; back-to-back read after write to the same address returns the new data.
- Reset asserted mid-sweep or mid-pipeline immediately zeroes q, q_valid and perr, discards in-flight responses, and restarts the sweep from 0.

## Configuration
- SP_RAM_PARITY_EN defined:
  - One even-parity bit is stored per lane and written with the lane.
  - It is checked on read and on write responses.
  - perr = OR of the lane mismatches, asserted with q_valid.
  - The sweep writes parity 0.
- SP_RAM_PARITY_EN undefined: no parity storage; perr is tied to 0.

## Structure
- Shared package sp_ram_pkg holds:
  - RDW_READ_FIRST / RDW_WRITE_FIRST / RDW_NO_CHANGE constants.
  - The state enum (CLEAR, READY).
  - A per-lane parity function.
- One sub-module, sp_ram_clear_seq, holds the FSM, sweep_addr counter and busy. It drives the write-port mux select.
- The array and the lane merge stay in the top.

## Test plan
1. Reset, release rst; hold en = 0 → busy = 1 for exactly 64 cycles, then 0; a read of any address returns 0x00.
2. Write 0x01/0x02/0x03 to addr 0/1/2 (be = 1), then read 0, 1, 2 → q = 0x01, 0x02, 0x03 with q_valid one cycle after each read; with OUT_REG = 1, two cycles after.
3. DATA_W = 32: write 0xAABBCCDD to addr 5, then write 0x11223344 with be = 4'b0101 → read returns 0xAA22CC44.
4. RDW_MODE sweep: addr 1 holds 0x02; write 0x04 → READ_FIRST q = 0x02, WRITE_FIRST q = 0x04, NO_CHANGE q unchanged with q_valid = 0; a subsequent read returns 0x04 in all modes.
5. Pulse clr together with en = 1 (write 0x55 to addr 3) → write is dropped, busy = 1 for 64 cycles, addr 3 reads 0x00. Assert rst at sweep cycle 30 → sweep restarts; busy stays high for 64 cycles after release.
6. SP_RAM_PARITY_EN: write 0x0F, force a stored data bit flip via hierarchical access, read → q_valid = 1, perr = 1; an unflipped word gives perr = 0.
